mlp_layer_sequencer: RTL
========================

# mlp_layer_sequencer

Parametrised successor to the fixed two-round neuron address controller. Sequences a fully connected multi-layer perceptron of up to four layers, each with its own input and output sizes. For every output neuron it generates input, weight and output addresses, accumulates the signed products returned by the SRAMs, applies ReLU and a fixed-point rescale, and writes the result. It sits between the input/weight SRAM templates and the output buffer, and uses a start/busy/done handshake in place of free-running operation.

## Interface
- DATA_W, 16, signed width of in_data, w_data and out_data
- ADDR_W, 4, width of in_addr and out_addr; a layer size may be at most 2^ADDR_W
- WADDR_W, 8, width of w_addr
- NUM_LAYERS, 2, number of layers to run, 1..4
- IN_SIZES, {4'd0,4'd0,4'd5,4'd13}, packed ADDR_W-bit input count per layer, layer 0 in the LSBs; an entry of 0 encodes 2^ADDR_W
- OUT_SIZES, {4'd0,4'd0,4'd3,4'd6}, packed output neuron count per layer, same encoding
- FRAC_BITS, 8, arithmetic right shift applied before saturation
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that begins a run; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at the end of the run
- layer  out  2  index of the current layer
- in_addr  out  ADDR_W  input SRAM read address
- w_addr  out  WADDR_W  weight SRAM read address; counts linearly across all layers
- in_data  in  DATA_W  input word; valid 1 cycle after in_addr
- w_data  in  DATA_W  weight word; valid 1 cycle after w_addr
- out_addr  out  ADDR_W  neuron index within the current layer
- out_data  out  DATA_W  activated result
- out_wr  out  1  one-cycle write strobe for out_addr/out_data

## Operation
- Reset: state IDLE. busy, done, out_wr, layer, in_addr, w_addr, out_addr, out_data and the accumulator are all 0.
- States and transitions:
  - IDLE→LOAD on start; layer, w_addr and out_addr are cleared.
  - LOAD (1 cycle): accumulator cleared, in_addr←0.
  - MAC: lasts IN_SIZES[layer] cycles. in_addr and w_addr increment every cycle. The product of the previous cycle's data is accumulated.
  - DRAIN (1 cycle): the last product is accumulated.
  - WRITE (1 cycle): out_wr=1.
  - After WRITE:
    - next neuron → LOAD;
    - last neuron of a non-final layer → LOAD with layer+1 and out_addr←0;
    - final layer → DONE.
  - DONE (1 cycle): done=1, busy=0. Then → IDLE.
- In MAC, in_addr stops at IN_SIZES-1 (it does not wrap). w_addr is not reset between neurons or layers. w_addr wraps modulo 2^WADDR_W.
- Arithmetic:
  - product = signed DATA_W×DATA_W, giving 2·DATA_W bits;
  - accumulator = 2·DATA_W+ADDR_W bits, signed, cannot overflow;
  - out_data = 0 if acc<0, else min(acc>>>FRAC_BITS, 2^(DATA_W-1)-1).
- start while busy is ignored. start on the same cycle as DONE is ignored.
- rst low mid-run: forced to the reset values on the next edge. No partial write and no done pulse are produced.

## Timing
- Per neuron: IN+3 cycles (LOAD + IN×MAC + DRAIN + WRITE).
- Run latency from the start edge to the done pulse: Σ_l OUT_l·(IN_l+3) + 1 cycles.
- SRAM read latency is exactly 1 cycle; no stall input.
- out_data and out_wr are registered and valid together in the WRITE cycle.
- layer changes on the edge after the last WRITE of a layer.

## Configuration
- MLP_SEQ_BIAS_EN defined:
  - adds output bias_addr (ADDR_W+2 bits) = {layer, out_addr}, driven in LOAD;
  - adds input bias_data (DATA_W); it is sign-extended, shifted left by FRAC_BITS, and loaded into the accumulator in DRAIN alongside the last product;
  - cycle counts are unchanged.
- Undefined: no bias ports; the accumulator starts at 0.

## Test plan
- Reset/idle: hold rst=0 for 3 cycles, then release → all outputs 0, busy=0; no out_wr for 20 cycles without start.
- Default run: all in_data=256 (1.0), all w_data=256 → six writes in layer 0 with out_data=13·256=3328, then three in layer 1 with out_data=5·256=1280. done occurs 6·16+3·8+1=121 cycles after start, and w_addr ends at 93.
- ReLU/saturation: w_data=-256 → out_data=0. in_data=w_data=32767 → out_data=32767.
- start during busy, and start in the DONE cycle → ignored; exactly 9 out_wr pulses in total.
- rst low at cycle 40 of a run → outputs zero on the next edge; a fresh start reproduces the full default-run sequence.
- MLP_SEQ_BIAS_EN: bias_data=-3328 with inputs and weights of 1.0 → layer 0 out_data=0. bias_data=256 → out_data=3584.

Source files
------------

// File: rtl/mlp_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_layer_sequencer
//
// Purpose
//   Sequences a fully connected multi-layer perceptron of up to four layers.
//   For every output neuron of every layer it walks the input and weight
//   SRAMs, accumulates the signed products they return, applies ReLU and a
//   fixed-point rescale with saturation, and strobes the result into the
//   output buffer. A run is launched by a start pulse and reported by a
//   one-cycle done pulse; busy covers the run in between.
//
// Per-neuron schedule (IN = input count of the current layer)
//   LOAD  (1)  : accumulator cleared, in_addr returns to 0
//   MAC   (IN) : one address pair issued per cycle; product of the data
//                returned for the previous address pair is accumulated
//   DRAIN (1)  : the last product is accumulated, result is activated
//   WRITE (1)  : out_wr / out_data / out_addr presented together
//
// Parameters
//   DATA_W      signed width of in_data, w_data and out_data
//   ADDR_W      width of in_addr / out_addr; layer sizes up to 2^ADDR_W
//   WADDR_W     width of w_addr (wraps modulo 2^WADDR_W)
//   NUM_LAYERS  number of layers per run, 1..4
//   IN_SIZES    packed ADDR_W-bit input counts, layer 0 in the LSBs, 0 = 2^ADDR_W
//   OUT_SIZES   packed ADDR_W-bit output neuron counts, same encoding
//   FRAC_BITS   arithmetic right shift applied before saturation
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-low reset
//   start      in   one-cycle pulse that begins a run (ignored unless idle)
//   busy       out  high from the cycle after an accepted start until done
//   done       out  one-cycle pulse at the end of a run
//   layer      out  index of the layer being processed
//   in_addr    out  input SRAM read address
//   w_addr     out  weight SRAM read address, linear across all layers
//   in_data    in   input word, valid one cycle after in_addr
//   w_data     in   weight word, valid one cycle after w_addr
//   out_addr   out  neuron index within the current layer
//   out_data   out  activated result
//   out_wr     out  one-cycle write strobe for out_addr / out_data
//
// Optional feature (macro MLP_SEQ_BIAS_EN)
//   bias_addr  out  {layer, out_addr} of the neuron being started, set for LOAD
//   bias_data  in   per-neuron bias; sign-extended, scaled by 2^FRAC_BITS and
//                   added in DRAIN together with the last product
//   Without the macro there are no bias ports and each neuron starts at 0.
// -----------------------------------------------------------------------------
module mlp_layer_sequencer #(
   parameter int                  DATA_W     = 16,
   parameter int                  ADDR_W     = 4,
   parameter int                  WADDR_W    = 8,
   parameter int                  NUM_LAYERS = 2,
   parameter logic [4*ADDR_W-1:0] IN_SIZES   = {4'd0, 4'd0, 4'd5, 4'd13},
   parameter logic [4*ADDR_W-1:0] OUT_SIZES  = {4'd0, 4'd0, 4'd3, 4'd6},
   parameter int                  FRAC_BITS  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               layer,
   output logic [ADDR_W-1:0]        in_addr,
   output logic [WADDR_W-1:0]       w_addr,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic signed [DATA_W-1:0] w_data,
`ifdef MLP_SEQ_BIAS_EN
   output logic [ADDR_W+1:0]        bias_addr,
   input  logic signed [DATA_W-1:0] bias_data,
`endif
   output logic [ADDR_W-1:0]        out_addr,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_wr
);

   // Product of two DATA_W signed words, and an accumulator wide enough to
   // sum 2^ADDR_W of them without overflow.
   localparam int PROD_W = 2 * DATA_W;
   localparam int ACC_W  = 2 * DATA_W + ADDR_W;

   // Largest positive value out_data can carry.
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);

   localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MAC,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                  state;
   logic signed [ACC_W-1:0] acc;

   // ---------------------------------------------------------------------------
   // Layer geometry
   // A size entry of 0 means 2^ADDR_W; subtracting one modulo 2^ADDR_W turns
   // every encoding, including 0, directly into the index of the last element.
   // ---------------------------------------------------------------------------
   logic [ADDR_W-1:0] in_last;
   logic [ADDR_W-1:0] out_last;

   // NOTE: every signal assigned in an always_comb gets a value on entry to the
   // block, so no path can leave it unassigned and infer a latch.
   always_comb begin
      in_last  = IN_SIZES[layer*ADDR_W +: ADDR_W] - ADDR_W'(1);
      out_last = OUT_SIZES[layer*ADDR_W +: ADDR_W] - ADDR_W'(1);
   end

   // ---------------------------------------------------------------------------
   // Datapath
   // prod_ext is the sign-extended product of the words currently returned by
   // the SRAMs, i.e. the pair addressed in the previous cycle.
   // ---------------------------------------------------------------------------
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_drain;
   logic signed [ACC_W-1:0]  acc_shift;
   logic signed [DATA_W-1:0] act;

`ifdef MLP_SEQ_BIAS_EN
   logic signed [ACC_W-1:0]  bias_ext;
`endif

   always_comb begin
      prod     = in_data * w_data;
      prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
`ifdef MLP_SEQ_BIAS_EN
      // Bias is expressed in output units, so it is aligned with the
      // accumulator's fixed point before it is added.
      bias_ext  = $signed({{(ACC_W - DATA_W){bias_data[DATA_W-1]}}, bias_data}) <<< FRAC_BITS;
      acc_drain = acc + prod_ext + bias_ext;
`else
      acc_drain = acc + prod_ext;
`endif
   end

   // ReLU, rescale and saturate the final sum of a neuron.
   always_comb begin
      acc_shift = acc_drain >>> FRAC_BITS;
      if (acc_drain < 0) begin
         act = '0;
      end else if (acc_shift > SAT_MAX) begin
         act = SAT_MAX[DATA_W-1:0];
      end else begin
         act = acc_shift[DATA_W-1:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencer
   // in_addr doubles as the MAC cycle counter: it starts each neuron at 0,
   // steps once per MAC cycle and parks on the last index instead of wrapping.
   // The first MAC cycle sees data for whatever was addressed during LOAD, so
   // nothing is accumulated until in_addr has moved past 0.
   // ---------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every register in
   // this block samples values from before the clock edge, whatever the order
   // of statements.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_wr    <= 1'b0;
         layer     <= '0;
         in_addr   <= '0;
         w_addr    <= '0;
         out_addr  <= '0;
         out_data  <= '0;
         acc       <= '0;
`ifdef MLP_SEQ_BIAS_EN
         bias_addr <= '0;
`endif
      end else begin
         // Strobes default low and are raised for exactly one cycle below.
         done   <= 1'b0;
         out_wr <= 1'b0;

         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_LOAD;
                  busy      <= 1'b1;
                  layer     <= '0;
                  w_addr    <= '0;
                  out_addr  <= '0;
`ifdef MLP_SEQ_BIAS_EN
                  bias_addr <= '0;
`endif
               end
            end

            S_LOAD: begin
               acc     <= '0;
               in_addr <= '0;
               state   <= S_MAC;
            end

            S_MAC: begin
               // The weight address runs on across neurons and layers.
               w_addr <= w_addr + WADDR_W'(1);
               if (in_addr != '0) begin
                  acc <= acc + prod_ext;
               end
               if (in_addr == in_last) begin
                  state <= S_DRAIN;
               end else begin
                  in_addr <= in_addr + ADDR_W'(1);
               end
            end

            S_DRAIN: begin
               acc      <= acc_drain;
               out_data <= act;
               out_wr   <= 1'b1;
               state    <= S_WRITE;
            end

            S_WRITE: begin
               if (out_addr != out_last) begin
                  out_addr  <= out_addr + ADDR_W'(1);
                  state     <= S_LOAD;
`ifdef MLP_SEQ_BIAS_EN
                  bias_addr <= {layer, out_addr + ADDR_W'(1)};
`endif
               end else if (layer != LAST_LAYER) begin
                  layer     <= layer + 2'd1;
                  out_addr  <= '0;
                  state     <= S_LOAD;
`ifdef MLP_SEQ_BIAS_EN
                  bias_addr <= {layer + 2'd1, {ADDR_W{1'b0}}};
`endif
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end

            // A start arriving here is deliberately dropped.
            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
